order_match_engine: RTL and testbench

- Upstream stage of the trade counter: accepts limit orders, keeps a small resting book per side, matches incoming orders against the best opposite price, and emits one pulse per fill.
- match_signal and enable_count feed the counter directly; the counter's halt_signal returns as halt_in and stops order intake.
- trade_price, trade_qty, best_bid and best_ask go to the VGA analytics path.

---
 rtl/ome_pkg.sv | 27 ++
 rtl/ome_book_side.sv | 98 +++++++++
 rtl/order_match_engine.sv | 203 ++++++++++++++++++++
 tb/tb_order_match_engine.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ome_pkg.sv
// ---------------------------------------------------------------------------
// ome_pkg
// Shared definitions for the order match engine: side encoding, FSM state
// type, empty-book price markers and default geometry.
// ---------------------------------------------------------------------------
package ome_pkg;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_PW    = 8;
  localparam int DEF_QW    = 8;

  localparam logic SIDE_BUY  = 1'b0;
  localparam logic SIDE_SELL = 1'b1;

  // Reported best prices when a side holds no valid slot (default width).
  localparam logic [DEF_PW-1:0] PRICE_EMPTY_BID = '0;
  localparam logic [DEF_PW-1:0] PRICE_EMPTY_ASK = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DECIDE,
    ST_MATCH,
    ST_INSERT
  } ome_state_t;

endpackage

// File: rtl/ome_book_side.sv
// ---------------------------------------------------------------------------
// ome_book_side
// DEPTH-slot resting storage for one side of the book.
//   clk, reset            : clock, async active-low reset
//   rd_idx / rd_*         : combinational slot read port (used while scanning)
//   dec_en/idx/qty        : subtract qty from a slot; slot invalidates at zero
//   ins_en/price/qty      : write into the lowest-index free slot
//   full                  : every slot valid (insert is ignored)
//   best_price, count     : registered summary, one cycle behind the slots
// IS_ASK selects which extreme is "best" and the empty-side marker.
// ---------------------------------------------------------------------------
module ome_book_side
  import ome_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PW     = DEF_PW,
  parameter int QW     = DEF_QW,
  parameter bit IS_ASK = 1'b0,
  parameter int IW     = $clog2(DEPTH),
  parameter int CW     = IW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] rd_idx,
  output logic          rd_valid,
  output logic [PW-1:0] rd_price,
  output logic [QW-1:0] rd_qty,
  input  logic          dec_en,
  input  logic [IW-1:0] dec_idx,
  input  logic [QW-1:0] dec_qty,
  input  logic          ins_en,
  input  logic [PW-1:0] ins_price,
  input  logic [QW-1:0] ins_qty,
  output logic          full,
  output logic [PW-1:0] best_price,
  output logic [CW-1:0] count
);

  localparam logic [PW-1:0] EMPTY_PRICE = IS_ASK ? {PW{1'b1}} : {PW{1'b0}};

  logic [DEPTH-1:0] slot_valid;
  logic [PW-1:0]    slot_price [DEPTH];
  logic [QW-1:0]    slot_qty   [DEPTH];

  logic [IW-1:0] free_idx;
  logic [PW-1:0] best_nxt;
  logic [CW-1:0] count_nxt;

  assign rd_valid = slot_valid[rd_idx];
  assign rd_price = slot_price[rd_idx];
  assign rd_qty   = slot_qty[rd_idx];
  assign full     = &slot_valid;

  // Walk downward so the last assignment is the lowest free index.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!slot_valid[i]) free_idx = IW'(i);
    end
  end

  always_comb begin
    best_nxt  = EMPTY_PRICE;
    count_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i]) begin
        count_nxt = count_nxt + CW'(1);
        if (IS_ASK ? (slot_price[i] < best_nxt) : (slot_price[i] > best_nxt))
          best_nxt = slot_price[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_price[i] <= '0;
        slot_qty[i]   <= '0;
      end
      best_price <= EMPTY_PRICE;
      count      <= '0;
    end else begin
      best_price <= best_nxt;
      count      <= count_nxt;
      if (dec_en) begin
        slot_qty[dec_idx] <= slot_qty[dec_idx] - dec_qty;
        if (slot_qty[dec_idx] == dec_qty) slot_valid[dec_idx] <= 1'b0;
      end
      if (ins_en && !full) begin
        slot_valid[free_idx] <= 1'b1;
        slot_price[free_idx] <= ins_price;
        slot_qty[free_idx]   <= ins_qty;
      end
    end
  end

endmodule

// File: rtl/order_match_engine.sv
// ---------------------------------------------------------------------------
// order_match_engine
// Limit-order matcher: one working order at a time is swept against the best
// opposite price, emitting one match_signal pulse per fill; remainder rests.
//   clk, reset                    : clock, async active-low reset
//   order_valid/ready/side/price/qty : order intake handshake
//   count_en, halt_in             : counter gating and intake stop
//   match_signal, enable_count    : fill pulse and gated count enable
//   trade_price, trade_qty        : last fill, held until the next fill
//   reject                        : pulse when an order is dropped
//   best_bid, best_ask, bid_count, ask_count : registered book summary
//
// state     | meaning
// ----------|----------------------------------------------------------
// IDLE      | waiting for an order; qty 0 is rejected here
// SCAN      | slot scan_idx of the opposite side examined for best price
// DECIDE    | crossing -> MATCH (fill latched), otherwise -> INSERT
// MATCH     | fill pulse; both quantities reduced; rescan if qty remains
// INSERT    | remainder rests in own side, or reject when side is full
// ---------------------------------------------------------------------------
module order_match_engine
  import ome_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int PW    = DEF_PW,
  parameter int QW    = DEF_QW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 order_valid,
  output logic                 order_ready,
  input  logic                 order_side,
  input  logic [PW-1:0]        order_price,
  input  logic [QW-1:0]        order_qty,
  input  logic                 count_en,
  input  logic                 halt_in,
  output logic                 match_signal,
  output logic                 enable_count,
  output logic [PW-1:0]        trade_price,
  output logic [QW-1:0]        trade_qty,
  output logic                 reject,
  output logic [PW-1:0]        best_bid,
  output logic [PW-1:0]        best_ask,
  output logic [$clog2(DEPTH):0] bid_count,
  output logic [$clog2(DEPTH):0] ask_count
);

  localparam int IW = $clog2(DEPTH);

  ome_state_t    state;
  logic          w_side;
  logic [PW-1:0] w_price;
  logic [QW-1:0] w_qty;
  logic [IW-1:0] scan_idx;
  logic          best_found;
  logic [IW-1:0] best_idx;
  logic [PW-1:0] best_px;

  logic [IW-1:0] rd_idx;
  logic          bid_rd_valid, ask_rd_valid;
  logic [PW-1:0] bid_rd_price, ask_rd_price;
  logic [QW-1:0] bid_rd_qty, ask_rd_qty;
  logic          bid_full, ask_full;
  logic          bid_dec_en, ask_dec_en, bid_ins_en, ask_ins_en;

  logic          opp_valid;
  logic [PW-1:0] opp_price;
  logic [QW-1:0] opp_qty;
  logic          own_full;
  logic          better;
  logic          crossing;
  logic [QW-1:0] fill;

  assign order_ready  = (state == ST_IDLE) && !halt_in;
  assign enable_count = match_signal & count_en;

  // During SCAN the read port walks the slots; afterwards it points at the
  // chosen best slot so DECIDE can size the fill.
  assign rd_idx = (state == ST_SCAN) ? scan_idx : best_idx;

  assign opp_valid = (w_side == SIDE_SELL) ? bid_rd_valid : ask_rd_valid;
  assign opp_price = (w_side == SIDE_SELL) ? bid_rd_price : ask_rd_price;
  assign opp_qty   = (w_side == SIDE_SELL) ? bid_rd_qty   : ask_rd_qty;
  assign own_full  = (w_side == SIDE_BUY)  ? bid_full     : ask_full;

  // Strict compare keeps the earlier (lower index) slot on price ties.
  assign better   = (w_side == SIDE_SELL) ? (opp_price > best_px) : (opp_price < best_px);
  assign crossing = best_found &&
                    ((w_side == SIDE_BUY) ? (w_price >= best_px) : (best_px >= w_price));
  assign fill     = (w_qty < opp_qty) ? w_qty : opp_qty;

  assign bid_dec_en = (state == ST_MATCH)  && (w_side == SIDE_SELL);
  assign ask_dec_en = (state == ST_MATCH)  && (w_side == SIDE_BUY);
  assign bid_ins_en = (state == ST_INSERT) && (w_side == SIDE_BUY)  && !bid_full;
  assign ask_ins_en = (state == ST_INSERT) && (w_side == SIDE_SELL) && !ask_full;

  ome_book_side #(.DEPTH(DEPTH), .PW(PW), .QW(QW), .IS_ASK(1'b0)) u_bid (
    .clk        (clk),
    .reset      (reset),
    .rd_idx     (rd_idx),
    .rd_valid   (bid_rd_valid),
    .rd_price   (bid_rd_price),
    .rd_qty     (bid_rd_qty),
    .dec_en     (bid_dec_en),
    .dec_idx    (best_idx),
    .dec_qty    (trade_qty),
    .ins_en     (bid_ins_en),
    .ins_price  (w_price),
    .ins_qty    (w_qty),
    .full       (bid_full),
    .best_price (best_bid),
    .count      (bid_count)
  );

  ome_book_side #(.DEPTH(DEPTH), .PW(PW), .QW(QW), .IS_ASK(1'b1)) u_ask (
    .clk        (clk),
    .reset      (reset),
    .rd_idx     (rd_idx),
    .rd_valid   (ask_rd_valid),
    .rd_price   (ask_rd_price),
    .rd_qty     (ask_rd_qty),
    .dec_en     (ask_dec_en),
    .dec_idx    (best_idx),
    .dec_qty    (trade_qty),
    .ins_en     (ask_ins_en),
    .ins_price  (w_price),
    .ins_qty    (w_qty),
    .full       (ask_full),
    .best_price (best_ask),
    .count      (ask_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      w_side       <= SIDE_BUY;
      w_price      <= '0;
      w_qty        <= '0;
      scan_idx     <= '0;
      best_found   <= 1'b0;
      best_idx     <= '0;
      best_px      <= '0;
      match_signal <= 1'b0;
      reject       <= 1'b0;
      trade_price  <= '0;
      trade_qty    <= '0;
    end else begin
      match_signal <= 1'b0;
      reject       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (order_valid && order_ready) begin
            w_side  <= order_side;
            w_price <= order_price;
            w_qty   <= order_qty;
            if (order_qty == '0) begin
              reject <= 1'b1;
            end else begin
              state      <= ST_SCAN;
              scan_idx   <= '0;
              best_found <= 1'b0;
            end
          end
        end
        ST_SCAN: begin
          if (opp_valid && (!best_found || better)) begin
            best_found <= 1'b1;
            best_idx   <= scan_idx;
            best_px    <= opp_price;
          end
          if (scan_idx == IW'(DEPTH - 1)) state <= ST_DECIDE;
          else                            scan_idx <= scan_idx + IW'(1);
        end
        ST_DECIDE: begin
          if (crossing) begin
            state        <= ST_MATCH;
            match_signal <= 1'b1;
            trade_price  <= best_px;
            trade_qty    <= fill;
          end else begin
            state <= ST_INSERT;
          end
        end
        ST_MATCH: begin
          w_qty <= w_qty - trade_qty;
          if (w_qty == trade_qty) begin
            state <= ST_IDLE;
          end else begin
            state      <= ST_SCAN;
            scan_idx   <= '0;
            best_found <= 1'b0;
          end
        end
        ST_INSERT: begin
          reject <= own_full;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_order_match_engine.sv
module tb_order_match_engine;

  localparam int DEPTH = 4;
  localparam int PW    = 8;
  localparam int QW    = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          order_valid = 1'b0;
  logic          order_ready;
  logic          order_side = 1'b0;
  logic [PW-1:0] order_price = '0;
  logic [QW-1:0] order_qty = '0;
  logic          count_en = 1'b1;
  logic          halt_in = 1'b0;
  logic          match_signal, enable_count, reject;
  logic [PW-1:0] trade_price, best_bid, best_ask;
  logic [QW-1:0] trade_qty;
  logic [2:0]    bid_count, ask_count;

  order_match_engine #(.DEPTH(DEPTH), .PW(PW), .QW(QW)) dut (
    .clk(clk), .reset(reset),
    .order_valid(order_valid), .order_ready(order_ready),
    .order_side(order_side), .order_price(order_price), .order_qty(order_qty),
    .count_en(count_en), .halt_in(halt_in),
    .match_signal(match_signal), .enable_count(enable_count),
    .trade_price(trade_price), .trade_qty(trade_qty), .reject(reject),
    .best_bid(best_bid), .best_ask(best_ask),
    .bid_count(bid_count), .ask_count(ask_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit is_match;
    int price;
    int qty;
    bit en;
  } ev_t;
  ev_t exp_q[$];

  // Reference book: side 0 = bids, side 1 = asks, slot positions explicit.
  bit m_valid [2][DEPTH];
  int m_price [2][DEPTH];
  int m_qty   [2][DEPTH];

  time last_match_t = 0;
  time accept_t = 0;
  int  last_ready_at = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int m_count(input int s);
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_valid[s][i]) n++;
    return n;
  endfunction

  function automatic int m_best(input int s);
    int b = (s == 0) ? 0 : 255;
    for (int i = 0; i < DEPTH; i++)
      if (m_valid[s][i] && ((s == 0) ? (m_price[s][i] > b) : (m_price[s][i] < b)))
        b = m_price[s][i];
    return b;
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < DEPTH; i++) m_valid[s][i] = 1'b0;
  endfunction

  task automatic model_order(input int side, input int price, input int qty, input bit en);
    int opp = 1 - side;
    int q = qty;
    ev_t e;
    if (q == 0) begin
      e = '{is_match: 1'b0, price: 0, qty: 0, en: 1'b0};
      exp_q.push_back(e);
      return;
    end
    while (q > 0) begin
      int bi = -1;
      for (int i = 0; i < DEPTH; i++)
        if (m_valid[opp][i] && (bi < 0 ||
            ((side == 1) ? (m_price[opp][i] > m_price[opp][bi])
                         : (m_price[opp][i] < m_price[opp][bi]))))
          bi = i;
      if (bi >= 0 && ((side == 0) ? (price >= m_price[opp][bi]) : (m_price[opp][bi] >= price))) begin
        int f = (q < m_qty[opp][bi]) ? q : m_qty[opp][bi];
        e = '{is_match: 1'b1, price: m_price[opp][bi], qty: f, en: en};
        exp_q.push_back(e);
        m_qty[opp][bi] -= f;
        q -= f;
        if (m_qty[opp][bi] == 0) m_valid[opp][bi] = 1'b0;
      end else begin
        int fi = -1;
        for (int i = DEPTH - 1; i >= 0; i--) if (!m_valid[side][i]) fi = i;
        if (fi < 0) begin
          e = '{is_match: 1'b0, price: 0, qty: 0, en: 1'b0};
          exp_q.push_back(e);
        end else begin
          m_valid[side][fi] = 1'b1;
          m_price[side][fi] = price;
          m_qty[side][fi]   = q;
        end
        q = 0;
      end
    end
  endtask

  // Monitor: every pulse the DUT presents is matched against the queue head.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && (match_signal || reject)) begin
        if (match_signal) last_match_t = $time;
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, match_signal, reject}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind_match", match_signal, e.is_match);
          chk("pulse_kind_reject", reject, !e.is_match);
          if (e.is_match && match_signal) begin
            chk("trade_price", trade_price, e.price);
            chk("trade_qty", trade_qty, e.qty);
            chk("enable_count", enable_count, e.en);
          end
        end
      end
    end
  end

  task automatic check_book(input string tag);
    chk({tag, "_pending_pulses"}, exp_q.size(), 0);
    chk({tag, "_best_bid"}, best_bid, m_best(0));
    chk({tag, "_best_ask"}, best_ask, m_best(1));
    chk({tag, "_bid_count"}, bid_count, m_count(0));
    chk({tag, "_ask_count"}, ask_count, m_count(1));
    if (m_count(0) > 0 && m_count(1) > 0)
      chk({tag, "_uncrossed"}, int'(best_bid < best_ask), 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 1;
    @(negedge clk);
    while (!order_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!order_ready) chk({tag, "_done_timeout"}, 0, 1);
    last_ready_at = n;
    repeat (2) @(negedge clk);
    check_book(tag);
  endtask

  task automatic send(input string tag, input int side, input int price, input int qty);
    int n = 0;
    model_order(side, price, qty, count_en);
    @(negedge clk);
    order_valid = 1'b1;
    order_side  = side[0];
    order_price = price[PW-1:0];
    order_qty   = qty[QW-1:0];
    while (!order_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!order_ready) chk({tag, "_accept_timeout"}, 0, 1);
    @(posedge clk);
    accept_t = $time;
    #1 order_valid = 1'b0;
    wait_done(tag);
  endtask

  initial begin
    m_clear();
    // Reset values while reset is held low.
    #12;
    chk("rst_match", match_signal, 0);
    chk("rst_enable_count", enable_count, 0);
    chk("rst_reject", reject, 0);
    chk("rst_trade_price", trade_price, 0);
    chk("rst_trade_qty", trade_qty, 0);
    chk("rst_best_bid", best_bid, 0);
    chk("rst_best_ask", best_ask, 255);
    chk("rst_bid_count", bid_count, 0);
    chk("rst_ask_count", ask_count, 0);
    chk("rst_ready", order_ready, 1);
    halt_in = 1'b1;
    #1 chk("rst_ready_halted", order_ready, 0);
    halt_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Single full fill, with latency.
    send("t1_buy", 0, 100, 10);
    send("t1_sell", 1, 100, 10);
    chk("t1_ready_latency", last_ready_at, 7);
    chk("t1_match_latency", int'((last_match_t - accept_t + 5) / 10), 6);

    // Sweep two ask levels.
    send("t2_ask_a", 1, 101, 5);
    send("t2_ask_b", 1, 100, 5);
    send("t2_buy", 0, 102, 8);
    chk("t2_best_ask", best_ask, 101);
    send("t2_clear", 0, 101, 2);

    // Non-crossing orders rest on both sides.
    send("t3_bid", 0, 50, 4);
    send("t3_ask", 1, 60, 4);

    // Full bid side rejects.
    send("t4_bid1", 0, 40, 1);
    send("t4_bid2", 0, 41, 1);
    send("t4_bid3", 0, 42, 1);
    send("t4_bid5", 0, 10, 1);
    chk("t4_bid_count", bid_count, 4);
    send("t4_sweep", 1, 1, 7);
    send("t4_clear", 0, 60, 4);

    // Halt blocks intake; count_en gates enable_count.
    send("t5_ask", 1, 70, 3);
    count_en = 1'b0;
    model_order(0, 70, 3, 1'b0);
    halt_in = 1'b1;
    @(negedge clk);
    order_valid = 1'b1;
    order_side  = 1'b0;
    order_price = 8'd70;
    order_qty   = 8'd3;
    repeat (5) @(negedge clk);
    chk("t5_halt_ready", order_ready, 0);
    chk("t5_halt_ask_count", ask_count, 1);
    halt_in = 1'b0;
    @(posedge clk);
    #1 order_valid = 1'b0;
    wait_done("t5_release");
    count_en = 1'b1;

    // Zero quantity is rejected without touching the book.
    send("t6_zero", 0, 90, 0);

    // Reset during SCAN of a crossing order.
    send("t7_bid", 0, 100, 5);
    @(negedge clk);
    order_valid = 1'b1;
    order_side  = 1'b1;
    order_price = 8'd90;
    order_qty   = 8'd5;
    @(posedge clk);
    #1 order_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t7_match", match_signal, 0);
    chk("t7_trade_price", trade_price, 0);
    chk("t7_trade_qty", trade_qty, 0);
    chk("t7_best_bid", best_bid, 0);
    chk("t7_best_ask", best_ask, 255);
    chk("t7_bid_count", bid_count, 0);
    chk("t7_ready", order_ready, 1);
    m_clear();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check_book("t7_after");

    // Randomized traffic around a narrow price band.
    for (int k = 0; k < 40; k++) begin
      int side  = int'($urandom_range(1, 0));
      int price = int'($urandom_range(110, 90));
      int qty   = ($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(6, 1));
      count_en  = 1'($urandom_range(1, 0));
      send("rnd", side, price, qty);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
